// File: rtl/detector_jogada_pkg.sv
// detector_jogada_pkg: state codes and debounce default shared by the play detector and control unit.
package detector_jogada_pkg;

    localparam int DEBOUNCE_DEFAULT = 20;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        FILTRA        = 2'd1,
        ESPERA_SOLTAR = 2'd2
    } estado_t;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sincronizador_4b.sv
// sincronizador_4b: two-flop synchronizer for the four raw button lines.
module sincronizador_4b (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'd0;
            sync_q <= 4'd0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: debounces four buttons and reports one play per press-release cycle.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       multipla,
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DC_M1 = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    botoes_s;
    estado_t       estado_q, estado_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          tem_q, tem_d;
    logic          mult_q, mult_d;

    sincronizador_4b u_sync (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (botoes_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            cand_q   <= 4'd0;
            cnt_q    <= '0;
            jogada_q <= 4'd0;
            tem_q    <= 1'b0;
            mult_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            jogada_q <= jogada_d;
            tem_q    <= tem_d;
            mult_q   <= mult_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        jogada_d = jogada_q;
        tem_d    = 1'b0;
        mult_d   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (enable && botoes_s != 4'd0) begin
                    cand_d   = botoes_s;
                    cnt_d    = CW'(1);
                    estado_d = FILTRA;
                end
            end
            FILTRA: begin
                if (!enable || botoes_s == 4'd0) begin
                    cnt_d    = '0;
                    estado_d = OCIOSO;
                end else if (botoes_s != cand_q) begin
                    cand_d = botoes_s;
                    cnt_d  = CW'(1);
                end else if (cnt_q < DC) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    jogada_d = one_hot(cand_q) ? cand_q : jogada_q;
                    tem_d    = one_hot(cand_q);
                    mult_d   = !one_hot(cand_q);
                    cnt_d    = '0;
                    estado_d = ESPERA_SOLTAR;
                end
            end
            ESPERA_SOLTAR: begin
                // counter holds the number of consecutive released cycles seen so far
                if (botoes_s != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q >= DC_M1) begin
                    cnt_d    = '0;
                    estado_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                estado_d = OCIOSO;
            end
        endcase
    end

    assign jogada     = jogada_q;
    assign tem_jogada = tem_q;
    assign multipla   = mult_q;
    assign db_estado  = {2'b00, estado_q};

endmodule
